dc1_xbit_wrq: RTL

//  Write-request queue directly upstream of the dcache pbit side array (dc1_xbit).

---
 rtl/dc1_xbit_wrq.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/dc1_xbit_wrq.sv
`default_nettype none
// ============================================================================
//  Module   : dc1_xbit_wrq
//  Purpose  : Write-request queue in front of the dcache pbit side array.
//             Accepts up to two pbit store updates per cycle into a circular
//             store queue. Line-fill inserts go into a one-entry hold register.
//             Each cycle it issues either the held insert or up to two stores
//             to the array's write0/write1/write_ins ports. All outputs are
//             registered. Two stores that read-modify-write the same RAM row
//             are never issued together.
//  Ports    : clk, rst (async, active-low)
//             st0_* / st1_*   : store requests (valid, addrE, addrO, odd,
//                               pbit, d128)
//             st_ready        : at least two free store entries
//             ins_*           : line-fill insert request (valid, mask,
//                               addrE, addrO, data)
//             ins_ready       : insert hold register is empty
//             write0_* / write1_* : array write ports (clkEn, addrE, addrO,
//                               odd, pbit, d128)
//             write_ins, write_data : insert bank mask and data to the array
//             count           : occupied store entries
//  Revision : 1.0  initial release
// ============================================================================
module dc1_xbit_wrq #(
    parameter int DEPTH = 8,
    parameter int AW    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st0_valid,
    input  logic [AW-1:0]           st0_addrE,
    input  logic [AW-1:0]           st0_addrO,
    input  logic                    st0_odd,
    input  logic [1:0]              st0_pbit,
    input  logic                    st0_d128,
    input  logic                    st1_valid,
    input  logic [AW-1:0]           st1_addrE,
    input  logic [AW-1:0]           st1_addrO,
    input  logic                    st1_odd,
    input  logic [1:0]              st1_pbit,
    input  logic                    st1_d128,
    output logic                    st_ready,
    input  logic                    ins_valid,
    input  logic [1:0]              ins_mask,
    input  logic [AW-1:0]           ins_addrE,
    input  logic [AW-1:0]           ins_addrO,
    input  logic [15:0]             ins_data,
    output logic                    ins_ready,
    output logic                    write0_clkEn,
    output logic [AW-1:0]           write0_addrE,
    output logic [AW-1:0]           write0_addrO,
    output logic                    write0_odd,
    output logic [1:0]              write0_pbit,
    output logic                    write0_d128,
    output logic                    write1_clkEn,
    output logic [AW-1:0]           write1_addrE,
    output logic [AW-1:0]           write1_addrO,
    output logic                    write1_odd,
    output logic [1:0]              write1_pbit,
    output logic                    write1_d128,
    output logic [1:0]              write_ins,
    output logic [15:0]             write_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int              c_PW        = $clog2(DEPTH);
    // Two free slots are needed so a dual enqueue can never overflow.
    localparam logic [c_PW:0]   c_READY_MAX = (c_PW+1)'(DEPTH - 2);

    typedef struct packed {
        logic [AW-1:0] addrE;
        logic [AW-1:0] addrO;
        logic          odd;
        logic [1:0]    pbit;
        logic          d128;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [c_PW-1:0]    r_head;
    logic [c_PW-1:0]    r_tail;
    logic [c_PW:0]      r_count;

    logic               r_insValid;
    logic [1:0]         r_insMask;
    logic [AW-1:0]      r_insAddrE;
    logic [AW-1:0]      r_insAddrO;
    logic [15:0]        r_insData;

    entry_t             w_st0;
    entry_t             w_st1;
    entry_t             w_head;
    entry_t             w_next;
    logic               w_stReady;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_headV;
    logic               w_nextV;
    logic               w_conflict;
    logic               w_pop0;
    logic               w_pop1;
    logic [c_PW-1:0]    w_st1Slot;
    logic [c_PW:0]      w_enqN;
    logic [c_PW:0]      w_popN;

    // Bank b is touched by the entry's own bank, and by the other bank too
    // when the selected chunk index is 0xf (the access spills into the next
    // chunk, which lives in the opposite bank).
    function automatic logic f_touch(input entry_t e, input logic bank);
        logic [AW-1:0] sel;
        sel = e.odd ? e.addrO : e.addrE;
        return (e.odd == bank) || (sel[3:0] == 4'hf);
    endfunction

    function automatic logic f_conflict(input entry_t a, input entry_t b);
        logic rowE;
        logic rowO;
        rowE = (a.addrE[AW-2:4] == b.addrE[AW-2:4]);
        rowO = (a.addrO[AW-2:4] == b.addrO[AW-2:4]);
        return (f_touch(a, 1'b0) && f_touch(b, 1'b0) && rowE) ||
               (f_touch(a, 1'b1) && f_touch(b, 1'b1) && rowO);
    endfunction

    assign w_st0      = {st0_addrE, st0_addrO, st0_odd, st0_pbit, st0_d128};
    assign w_st1      = {st1_addrE, st1_addrO, st1_odd, st1_pbit, st1_d128};

    assign w_stReady  = (r_count <= c_READY_MAX);
    assign w_acc0     = st0_valid & w_stReady;
    assign w_acc1     = st1_valid & w_stReady;
    // A lone st1 lands at the tail; behind st0 it takes the next slot.
    assign w_st1Slot  = r_tail + c_PW'(w_acc0);
    assign w_enqN     = (c_PW+1)'(w_acc0) + (c_PW+1)'(w_acc1);

    assign w_head     = r_mem[r_head];
    assign w_next     = r_mem[r_head + c_PW'(1)];
    assign w_headV    = (r_count != '0);
    assign w_nextV    = (r_count > (c_PW+1)'(1));
    assign w_conflict = f_conflict(w_head, w_next);

    // A held insert owns the cycle; stores wait behind it.
    assign w_pop0     = ~r_insValid & w_headV;
    assign w_pop1     = w_pop0 & w_nextV & ~w_conflict;
    assign w_popN     = (c_PW+1)'(w_pop0) + (c_PW+1)'(w_pop1);

    assign st_ready   = w_stReady;
    assign ins_ready  = ~r_insValid;
    assign count      = r_count;

    // Entry storage needs no reset: occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_acc0) begin
            r_mem[r_tail] <= w_st0;
        end
        if (w_acc1) begin
            r_mem[w_st1Slot] <= w_st1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_PW'(w_popN);
            r_tail  <= r_tail + c_PW'(w_enqN);
            r_count <= r_count + w_enqN - w_popN;
        end
    end

    // Insert hold: a held insert always issues in the cycle after capture,
    // so the register is empty again one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_insValid <= 1'b0;
            r_insMask  <= '0;
            r_insAddrE <= '0;
            r_insAddrO <= '0;
            r_insData  <= '0;
        end else if (r_insValid) begin
            r_insValid <= 1'b0;
        end else if (ins_valid) begin
            r_insValid <= 1'b1;
            r_insMask  <= ins_mask;
            r_insAddrE <= ins_addrE;
            r_insAddrO <= ins_addrO;
            r_insData  <= ins_data;
        end
    end

    // Registered array-side outputs; fields of an idle port keep their value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write0_clkEn <= 1'b0;
            write0_addrE <= '0;
            write0_addrO <= '0;
            write0_odd   <= 1'b0;
            write0_pbit  <= '0;
            write0_d128  <= 1'b0;
            write1_clkEn <= 1'b0;
            write1_addrE <= '0;
            write1_addrO <= '0;
            write1_odd   <= 1'b0;
            write1_pbit  <= '0;
            write1_d128  <= 1'b0;
            write_ins    <= '0;
            write_data   <= '0;
        end else begin
            write0_clkEn <= w_pop0;
            write1_clkEn <= w_pop1;
            write_ins    <= r_insValid ? r_insMask : 2'b00;
            if (r_insValid) begin
                // The insert shares write0's address lines.
                write0_addrE <= r_insAddrE;
                write0_addrO <= r_insAddrO;
                write_data   <= r_insData;
            end else if (w_pop0) begin
                write0_addrE <= w_head.addrE;
                write0_addrO <= w_head.addrO;
                write0_odd   <= w_head.odd;
                write0_pbit  <= w_head.pbit;
                write0_d128  <= w_head.d128;
            end
            if (w_pop1) begin
                write1_addrE <= w_next.addrE;
                write1_addrO <= w_next.addrO;
                write1_odd   <= w_next.odd;
                write1_pbit  <= w_next.pbit;
                write1_d128  <= w_next.d128;
            end
        end
    end

endmodule
`default_nettype wire
